// File: rtl/weights_bank_pkg.sv
// Shared command encodings and FSM state type for the weight bank slice.
package weights_bank_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_BURST = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/weights_bank_ram.sv
// Single-port synchronous row RAM; read data appears one cycle after the address.
module weights_bank_ram
    import weights_bank_pkg::*;
#(
    parameter int ADDR_DEPTH = 12,
    parameter int ROW_WIDTH  = 15
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_DEPTH-1:0] addr_i,
    input  logic [ROW_WIDTH-1:0]  wdata_i,
    output logic [ROW_WIDTH-1:0]  rdata_o
);

    logic [ROW_WIDTH-1:0] mem_q [2**ADDR_DEPTH];
    logic [ROW_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/weights_bank_stream.sv
// Weight row bank: writes, single reads and handshaked bursts through a
// 2-entry output buffer with wrap-around addressing and sticky command errors.
module weights_bank_stream
    import weights_bank_pkg::*;
#(
    parameter int ADDR_DEPTH      = 12,
    parameter int WEIGHT_PREC     = 5,
    parameter int WEIGHTS_PER_ROW = 3,
    parameter int LEN_W           = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [1:0]                           control,
    input  logic [ADDR_DEPTH-1:0]                address,
    input  logic [LEN_W-1:0]                     burst_len,
    input  logic [WEIGHT_PREC*WEIGHTS_PER_ROW-1:0] write_data,
    output logic [WEIGHT_PREC*WEIGHTS_PER_ROW-1:0] read_data,
    output logic                                 read_valid,
    input  logic                                 read_ready,
    output logic                                 read_last,
    output logic                                 busy,
    output logic                                 cmd_error
);

    localparam int ROW_WIDTH = WEIGHT_PREC * WEIGHTS_PER_ROW;

    cmd_e                  cmd;
    state_e                state_q, state_d;
    logic [ADDR_DEPTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic                  err_q, err_d;
    logic                  infl_q, infl_d;
    logic                  infl_last_q, infl_last_d;
    logic [1:0]            occ_q, occ_d;
    logic [ROW_WIDTH-1:0]  buf0_q, buf0_d, buf1_q, buf1_d;
    logic                  last0_q, last0_d, last1_q, last1_d;

    logic                  ram_we;
    logic [ADDR_DEPTH-1:0] ram_addr;
    logic [ROW_WIDTH-1:0]  ram_rdata;
    logic                  issue, issue_last;
    logic                  valid, pop;
    logic [2:0]            fill;
    logic                  can_issue;

    weights_bank_ram #(
        .ADDR_DEPTH(ADDR_DEPTH),
        .ROW_WIDTH (ROW_WIDTH)
    ) u_ram (
        .clk_i  (clock),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .wdata_i(write_data),
        .rdata_o(ram_rdata)
    );

    assign cmd   = cmd_e'(control);
    assign valid = (occ_q != 2'd0);
    assign pop   = valid & read_ready;
    // A read issued now lands in the buffer at the end of next cycle; only issue
    // if that slot is guaranteed even when nothing pops next cycle.
    assign fill      = {1'b0, occ_q} + {2'b0, infl_q} - {2'b0, pop};
    assign can_issue = (fill <= 3'd1);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        err_d      = err_q;
        ram_we     = 1'b0;
        ram_addr   = addr_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The first read goes straight from the command address so the
                // first beat is valid two cycles after acceptance.
                ram_addr = address;
                case (cmd)
                    CMD_WRITE: ram_we = 1'b1;
                    CMD_READ: begin
                        issue      = 1'b1;
                        issue_last = 1'b1;
                        addr_d     = address + 1'b1;
                        rem_d      = '0;
                        state_d    = ST_DRAIN;
                    end
                    CMD_BURST: begin
                        if (burst_len == '0) begin
                            err_d = 1'b1;
                        end else begin
                            issue      = 1'b1;
                            issue_last = (burst_len == LEN_W'(1));
                            addr_d     = address + 1'b1;
                            rem_d      = burst_len - 1'b1;
                            state_d    = issue_last ? ST_DRAIN : ST_STREAM;
                        end
                    end
                    default: ;
                endcase
            end
            ST_STREAM: begin
                if (cmd != CMD_IDLE) begin
                    err_d = 1'b1;
                end
                if (can_issue) begin
                    issue      = 1'b1;
                    issue_last = (rem_q == LEN_W'(1));
                    addr_d     = addr_q + 1'b1;
                    rem_d      = rem_q - 1'b1;
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (cmd != CMD_IDLE) begin
                    err_d = 1'b1;
                end
                if (pop && last0_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        infl_d      = issue;
        infl_last_d = issue_last;
        occ_d       = occ_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        last0_d     = last0_q;
        last1_d     = last1_q;
        case ({infl_q, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d  = ram_rdata;
                    last0_d = infl_last_q;
                end else begin
                    buf1_d  = ram_rdata;
                    last1_d = infl_last_q;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d  = buf1_q;
                last0_d = last1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d  = ram_rdata;
                    last0_d = infl_last_q;
                end else begin
                    buf0_d  = buf1_q;
                    last0_d = last1_q;
                    buf1_d  = ram_rdata;
                    last1_d = infl_last_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            err_q       <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            occ_q       <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            occ_q       <= occ_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            last0_q     <= last0_d;
            last1_q     <= last1_d;
        end
    end

    assign read_valid = valid;
    assign read_data  = valid ? buf0_q : '0;
    assign read_last  = valid & last0_q;
    assign busy       = (state_q != ST_IDLE);
    assign cmd_error  = err_q;

endmodule

// File: doc/weights_bank_stream.md
# weights_bank_stream

Parametrised successor to the CatRecognizer weight register file: stores packed weight rows and serves them to the datapath either as single reads or as multi-row bursts with a valid/ready handshake. It sits between the AMBA-facing controller, which writes rows and issues commands, and the MAC datapath, which consumes weight rows. It adds configurable weights-per-row, burst streaming with back-pressure, address wrap-around and command-error reporting. Its read bus is always driven; there is no tri-state output.

## Interface
- ADDR_DEPTH, 12, address bits; the bank holds 2**ADDR_DEPTH rows
- WEIGHT_PREC, 5, bits per weight (5/8/16 in use)
- WEIGHTS_PER_ROW, 3, weights packed per row; ROW_WIDTH = WEIGHT_PREC*WEIGHTS_PER_ROW (localparam)
- LEN_W, 8, width of the burst length field
- clock  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- control  in  2  command: 00 idle, 01 write, 10 single read, 11 burst read
- address  in  ADDR_DEPTH  row address, or the start row for a burst
- burst_len  in  LEN_W  number of rows in a burst; sampled only with 11
- write_data  in  ROW_WIDTH  row to store
- read_data  out  ROW_WIDTH  row data; 0 whenever read_valid=0
- read_valid  out  1  read_data holds a beat
- read_ready  in  1  consumer accepts the beat
- read_last  out  1  high with the final beat of a single read or burst
- busy  out  1  high while a read is in flight or a beat is pending
- cmd_error  out  1  sticky; cleared only by reset

## Operation
- FSM states: IDLE, STREAM, DRAIN.
- IDLE, command 01: row[address] <= write_data. Takes one cycle; busy stays 0.
- IDLE, command 10: behaves as a burst of length 1.
- IDLE, command 11 with burst_len>0: latch address and burst_len, go to STREAM.
- IDLE, command 11 with burst_len=0: command ignored; cmd_error <= 1.
- STREAM: issue one RAM read per cycle while the output buffer has space. Address increments modulo 2**ADDR_DEPTH, so 0xFFF wraps to 0x000 at ADDR_DEPTH=12. After the last read is issued, go to DRAIN.
- DRAIN: wait until the last beat is accepted (read_valid & read_ready & read_last), then go to IDLE.
- Any non-00 command while busy=1 is dropped and sets cmd_error. Row contents are unchanged by a dropped write.
- A beat transfers on read_valid & read_ready. read_data and read_last hold stable while read_valid=1 and read_ready=0.
- Row memory is not cleared by reset. Contents are undefined until written; the bench preloads rows via writes.

## Timing
- Reset values: read_data=0, read_valid=0, read_last=0, busy=0, cmd_error=0, FSM=IDLE.
- Reset during a burst aborts it immediately. No further beats are produced; previously written rows are preserved.
- Command accepted at cycle T: busy=1 from T+1, first beat valid at T+2. Read latency is the 1-cycle synchronous RAM plus the output register.
- With read_ready held high, throughput is 1 beat per cycle. A burst of N ends with read_last at T+1+N, and busy falls the cycle after that last transfer.
- Back-pressure: a 2-entry output buffer absorbs the in-flight RAM read, so no beat is lost or duplicated when read_ready drops for any number of cycles.
- busy=1 in the same cycle the last beat transfers. A command presented in that cycle is dropped (cmd_error); commands are accepted from the following cycle.
- Write followed by a read of the same row on the next cycle returns the new data.

## Structure
- Package weights_bank_pkg:
  - control encodings CMD_IDLE, CMD_WRITE, CMD_READ, CMD_BURST
  - FSM state typedef
  - no width parameters; those stay module parameters
- Sub-module weights_bank_ram:
  - single-port synchronous RAM, 2**ADDR_DEPTH x ROW_WIDTH
  - write and read share the port; writes occur only in IDLE, so there is no collision
- The top level holds the FSM, address and length counters, the 2-entry output buffer and error logic.

## Test plan
- Write 0x1ABC to row 5, single read of row 5 with ready high -> read_data=0x1ABC, read_valid and read_last at T+2, busy=0 at T+3.
- Rows 10..13 = 1,2,3,4; burst of 4 from row 10 with ready high -> beats 1,2,3,4 on consecutive cycles, read_last only on beat 4.
- Same burst with read_ready toggling 1,0,0,1,0,1... -> exactly 4 transfers in order 1..4; data stable while stalled.
- Burst of 3 from row 0xFFE (ADDR_DEPTH=12) -> rows 0xFFE, 0xFFF, 0x000 are returned.
- burst_len=0, or a write issued while busy -> cmd_error=1, memory unchanged, active burst completes normally.
- Assert reset during beat 2 of an 8-row burst -> the next cycle shows all outputs at 0 and FSM=IDLE; a later single read shows row contents intact.
